// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/data arbiter sequencing single accesses to the unified memory.
// Word address 0 is rejected with an error response and never reaches the memory.
module mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_rvalid_o,
    output logic              if_err_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_rvalid_o,
    output logic              dm_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state_q, state_d;
    logic last_q, last_d, owner_q, owner_d, err_q, err_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic gnt, pick_dm, done;
    logic [ADDR_W-1:0] req_addr;
    // last_q/owner_q: 1 = data port, 0 = fetch port
    assign gnt = state_q == IDLE && !rst && (if_req_i || dm_req_i);
    assign pick_dm = dm_req_i && (!if_req_i || !last_q);
    assign req_addr = pick_dm ? dm_addr_i : if_addr_i;
    assign done = state_q == DONE && !rst;
    assign if_gnt_o = gnt && !pick_dm;
    assign dm_gnt_o = gnt && pick_dm;
    assign if_rvalid_o = done && !owner_q;
    assign dm_rvalid_o = done && owner_q;
    assign if_err_o = if_rvalid_o && err_q;
    assign dm_err_o = dm_rvalid_o && err_q;
    assign if_rdata_o = if_rdata_q;
    assign dm_rdata_o = dm_rdata_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o = mem_we_q;
    always_comb begin
        state_d = state_q;
        last_d = last_q;
        owner_d = owner_q;
        err_d = err_q;
        mem_we_d = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt) begin
                    owner_d = pick_dm;
                    last_d = pick_dm;
                    err_d = req_addr == '0;
                    state_d = req_addr == '0 ? DONE : ACCESS;
                    if (req_addr != '0) begin
                        mem_addr_d = req_addr;
                        mem_wdata_d = dm_wdata_i;
                        mem_we_d = pick_dm && dm_we_i;
                    end
                end
            end
            ACCESS: begin
                // mem_we_q still holds the latched store flag here
                if_rdata_d = !mem_we_q && !owner_q ? mem_rdata_i : if_rdata_q;
                dm_rdata_d = !mem_we_q && owner_q ? mem_rdata_i : dm_rdata_q;
                mem_we_d = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q <= 1'b1;
            owner_q <= 1'b0;
            err_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            owner_q <= owner_d;
            err_q <= err_d;
            mem_we_q <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with byte memory model and spec-level arbitration/timing reference.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic if_req, if_gnt, if_rvalid, if_err;
    logic [13:0] if_addr;
    logic [15:0] if_rdata;
    logic dm_req, dm_we, dm_gnt, dm_rvalid, dm_err;
    logic [13:0] dm_addr, mem_addr, mem_am1;
    logic [15:0] dm_wdata, dm_rdata, mem_wdata, mem_rdata;
    logic mem_we;
    logic poke_en;
    logic [13:0] poke_a;
    logic [15:0] poke_d;
    logic [7:0] mem [16384] = '{default: 8'h00};
    logic [7:0] ref_mem [16384] = '{default: 8'h00};
    typedef struct {
        logic port;
        logic st;
        logic e;
        logic [15:0] data;
        logic [13:0] addr;
        logic [15:0] wdata;
        int due;
    } exp_t;
    exp_t q[$];
    int cyc = 0;
    int vectors = 0;
    int errors = 0;
    int next_free = 0;
    logic last_dm = 1'b1;
    logic [15:0] model_rd [2] = '{16'h0, 16'h0};
    logic gf, gd, hold_f, hold_d;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_rdata_o(if_rdata),
        .if_rvalid_o(if_rvalid), .if_err_o(if_err),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt), .dm_rdata_o(dm_rdata), .dm_rvalid_o(dm_rvalid), .dm_err_o(dm_err),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_rdata_i(mem_rdata)
    );

    // byte memory: high byte at addr, low byte at addr-1 (wrapping)
    assign mem_am1 = mem_addr - 14'd1;
    assign mem_rdata = {mem[mem_addr], mem[mem_am1]};
    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_a] <= poke_d[15:8];
            mem[poke_a - 14'd1] <= poke_d[7:0];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata[15:8];
            mem[mem_am1] <= mem_wdata[7:0];
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic logic [13:0] raddr();
        int r = $urandom_range(0, 15);
        if (r == 0) return 14'h0;
        if (r == 1) return 14'h1;
        if (r == 2) return 14'h3FFF;
        if (r < 10) return 14'($urandom_range(1, 40));
        return 14'($urandom);
    endfunction

    // reference: grant legality/priority and expected response derived from the rules
    task automatic observe();
        logic free, wf, wd;
        logic [13:0] a, am;
        exp_t x;
        free = !rst && cyc >= next_free;
        wf = free && if_req && (!dm_req || last_dm);
        wd = free && dm_req && (!if_req || !last_dm);
        chk("if_gnt", if_gnt, wf);
        chk("dm_gnt", dm_gnt, wd);
        gf = wf;
        gd = wd;
        if (wf || wd) begin
            a = wd ? dm_addr : if_addr;
            am = a - 14'd1;
            x.port = wd;
            x.st = wd && dm_we;
            x.e = a == 14'h0;
            x.addr = a;
            x.wdata = dm_wdata;
            x.due = x.e ? cyc + 1 : cyc + 2;
            next_free = x.e ? cyc + 2 : cyc + 3;
            if (!x.e && x.st) begin
                ref_mem[a] = dm_wdata[15:8];
                ref_mem[am] = dm_wdata[7:0];
            end else if (!x.e) begin
                model_rd[wd] = {ref_mem[a], ref_mem[am]};
            end
            x.data = model_rd[wd];
            q.push_back(x);
            last_dm = wd;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        if (gf && !hold_f) if_req = 1'b0;
        if (gd && !hold_d) dm_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((if_req || dm_req || q.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 20, 1);
    endtask

    task automatic dm_issue(input logic we, input logic [13:0] a, input logic [15:0] d);
        dm_req = 1'b1;
        dm_we = we;
        dm_addr = a;
        dm_wdata = d;
    endtask

    // monitor: pops expectations when a response is due and checks memory-side activity
    initial begin
        logic has, rv, ac;
        exp_t x;
        @(posedge clk);
        forever begin
            @(negedge clk);
            has = q.size() != 0;
            if (has) x = q[0];
            rv = has && x.due == cyc;
            ac = has && !x.e && cyc == x.due - 1;
            chk("if_rvalid", if_rvalid, rv && !x.port);
            chk("dm_rvalid", dm_rvalid, rv && x.port);
            chk("if_err", if_err, rv && !x.port && x.e);
            chk("dm_err", dm_err, rv && x.port && x.e);
            if (rv) begin
                chk(x.port ? "dm_rdata" : "if_rdata", x.port ? dm_rdata : if_rdata, x.data);
                void'(q.pop_front());
            end
            chk("mem_we", mem_we, ac && x.st);
            if (ac) chk("mem_addr", mem_addr, x.addr);
            if (ac && x.st) chk("mem_wdata", mem_wdata, x.wdata);
        end
    end

    initial begin
        logic [7:0] b0, b1;
        rst = 1'b1;
        hold_f = 1'b1;
        hold_d = 1'b1;
        if_req = 1'b1;
        if_addr = 14'h0021;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 14'h0031;
        dm_wdata = 16'h0;
        gf = 1'b0;
        gd = 1'b0;
        poke_en = 1'b1;
        poke_a = 14'h0011;
        poke_d = 16'hABCD;
        ref_mem[14'h0011] = 8'hAB;
        ref_mem[14'h0010] = 8'hCD;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
        @(negedge clk);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_dm_gnt", dm_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        tick();
        rst = 1'b0;
        // tie: both held from reset
        repeat (12) tick();
        hold_f = 1'b0;
        hold_d = 1'b0;
        drain();
        // single load
        dm_issue(1'b0, 14'h0011, 16'h0);
        drain();
        chk("single_load", dm_rdata, 16'hABCD);
        // store then fetch
        dm_issue(1'b1, 14'h0101, 16'h1234);
        drain();
        if_req = 1'b1;
        if_addr = 14'h0101;
        drain();
        chk("store_fetch", if_rdata, 16'h1234);
        // address 0 store must not touch memory
        b0 = mem[14'h0];
        b1 = mem[14'h3FFF];
        dm_issue(1'b1, 14'h0, 16'hBEEF);
        drain();
        chk("addr0_byte0", mem[14'h0], b0);
        chk("addr0_byte3fff", mem[14'h3FFF], b1);
        // reset during the ACCESS cycle of a store
        dm_issue(1'b1, 14'h0200, 16'h5A5A);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        next_free = 0;
        last_dm = 1'b1;
        model_rd[0] = 16'h0;
        model_rd[1] = 16'h0;
        ref_mem[14'h0200] = mem[14'h0200];
        ref_mem[14'h01FF] = mem[14'h01FF];
        if_req = 1'b1;
        if_addr = 14'h0200;
        drain();
        // fetch request raised in the DONE cycle of a data access
        dm_issue(1'b0, 14'h0011, 16'h0);
        tick();
        tick();
        if_req = 1'b1;
        if_addr = 14'h0011;
        tick();
        tick();
        drain();
        // random traffic
        repeat (3000) begin
            tick();
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1;
                if_addr = raddr();
            end
            if (!dm_req && $urandom_range(0, 2) == 0)
                dm_issue(1'($urandom), raddr(), 16'($urandom));
        end
        drain();
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the byte-addressed unified `memory` block (14-bit address, 16-bit word, high byte at `addr`, low byte at `addr-1`). It shares the single memory port between the instruction-fetch unit and the data (load/store) unit using round-robin arbitration. Each access runs as a fixed three-state sequence that holds address, data and write enable stable for one full cycle. Accesses whose word address is 0, which would wrap to byte 0x3FFF, are rejected with an error response.

## Interface
- `ADDR_W`, 14, byte address width.
- `DATA_W`, 16, word width; must be 16.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch word address; points at the high byte.
- `if_gnt`  out  1  one-cycle pulse: fetch request accepted.
- `if_rdata`  out  DATA_W  fetch read data; valid while `if_rvalid`=1.
- `if_rvalid`  out  1  one-cycle pulse: fetch complete.
- `if_err`  out  1  qualifies `if_rvalid`: address 0 was rejected.
- `dm_req`  in  1  data request; held until `dm_gnt`.
- `dm_we`  in  1  1 = store, 0 = load; sampled with `dm_req`.
- `dm_addr`  in  ADDR_W  data word address.
- `dm_wdata`  in  DATA_W  store data.
- `dm_gnt`, `dm_rdata`, `dm_rvalid`, `dm_err`  out  1/DATA_W/1/1  same meaning as the fetch-port signals.
- `mem_addr`  out  ADDR_W  address to `memory`; registered.
- `mem_wdata`  out  DATA_W  write data to `memory`; registered.
- `mem_we`  out  1  write enable to `memory`; registered.
- `mem_rdata`  in  DATA_W  read data from `memory`; combinational from `mem_addr`.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - Arbitrate among the asserted requests.
  - With both requests asserted, grant the port that was not granted last (`last` pointer). Reset sets `last` to the data port, so the fetch port wins the first tie.
  - On a grant: pulse the grant signal and latch owner, address, write data and `we`.
  - If the latched address is nonzero: load `mem_addr`/`mem_wdata`, set `mem_we` = latched `we`, go to ACCESS.
  - If the address is 0: set the error flag, do not touch the memory, go straight to DONE.
  - Update `last` to the granted port.
- **ACCESS** (exactly one cycle): memory ports held stable. At the clock edge:
  - capture `mem_rdata` into the owner's rdata register (loads and fetches only);
  - clear `mem_we`;
  - go to DONE.
- **DONE** (one cycle)
  - Pulse the owner's `rvalid`, plus `err` if the error flag is set.
  - For a store, the owner's rdata holds its previous value.
  - Return to IDLE.
- Requests asserted in ACCESS or DONE are not granted; they wait for IDLE.
- At most one access is in flight. Gnt/rvalid/err of the non-owner port stay 0.
- `if_rdata`/`dm_rdata` hold their last captured value until the next capture for that port.

## Timing
- Reset values:
  - FSM = IDLE;
  - all gnt/rvalid/err = 0;
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0;
  - `if_rdata` = `dm_rdata` = 0;
  - `last` = data port.
- Latency: request seen in IDLE at cycle N gives gnt at N, memory driven in N+1, rvalid at N+2.
- Error-path latency: gnt at N, rvalid+err at N+1.
- Throughput: one access per 3 cycles, or per 2 for an error.
- A requester may deassert `req` or change `addr` the cycle after `gnt`.
- `mem_we` is high for exactly one cycle per store and never high outside ACCESS.
- Reset mid-operation:
  - `rst` in ACCESS forces `mem_we` = 0 at that edge and returns to IDLE;
  - no rvalid is issued;
  - the write may or may not have landed in memory.
- Simultaneous `rst` and `req`: reset wins, no grant.

## Test plan
- **Single load:** memory bytes 0x0011=0xAB, 0x0010=0xCD; `dm_req`, `dm_addr`=0x0011 → `dm_gnt` at cycle 0, `mem_we`=0, `dm_rvalid` at cycle 2 with `dm_rdata`=0xABCD, `dm_err`=0.
- **Store then fetch:** store 0x1234 to 0x0101 → `mem_we` high exactly one cycle with `mem_addr`=0x0101. A following fetch from 0x0101 → `if_rdata`=0x1234.
- **Tie arbitration:** both ports request continuously from reset → grants in order fetch, data, fetch, data, 3 cycles apart; no overlapping rvalid.
- **Address 0:** `dm_req`, `dm_we`=1, `dm_addr`=0 → `dm_gnt` then `dm_rvalid`+`dm_err` the next cycle; `mem_we` never asserted; memory unchanged.
- **Reset mid-store:** assert `rst` in the ACCESS cycle of a store → next cycle FSM in IDLE, `mem_we`=0, no `dm_rvalid`; a fresh `if_req` is granted normally afterwards.
- **Request during busy:** `if_req` asserted in the DONE cycle of a data access → no `if_gnt` until the following IDLE cycle; `if_gnt` arrives exactly then.
